plb_wr_arbiter: RTL
===================

Name: plb_wr_arbiter

Overview:
- Shares the single PLB master IPIF write port between two write requesters, e.g. the rasteriser framebuffer writer (req 0) and a second engine (req 1).
- Accepts single-beat write requests, grants one requester at a time, and presents that requester's address/BE/data to the IPIF.
- Holds the grant until the transfer completes, routes CmdAck/Cmplt/Error back to the granted requester only, and handles IPIF rearbitrate by retrying.

Parameters:
- C_MST_AWIDTH, 32, IPIF master address width.
- C_MST_DWIDTH, 32, IPIF master data width.
- RETRY_GAP, 2, idle cycles with IP2Bus_MstWr_Req low after a rearbitrate, before reissuing (1..15).

Ports:
- PLB_clk  in  1  clock; all logic on rising edge.
- Bus2IP_Resetn  in  1  synchronous active-low reset.
- Req0_WrReq  in  1  requester 0 write request; held with addr/BE/data stable until Req0_CmdAck.
- Req0_Addr  in  C_MST_AWIDTH  requester 0 address.
- Req0_BE  in  C_MST_DWIDTH/8  requester 0 byte enables.
- Req0_WrData  in  C_MST_DWIDTH  requester 0 write data.
- Req0_CmdAck / Req0_Cmplt / Req0_Error  out  1 each  per-requester copies of the IPIF pulses.
- Req1_WrReq, Req1_Addr, Req1_BE, Req1_WrData, Req1_CmdAck, Req1_Cmplt, Req1_Error: same as requester 0.
- IP2Bus_MstWr_Req  out  1  registered write request to the IPIF.
- IP2Bus_MstRd_Req  out  1  tied 0.
- IP2Bus_Mst_Addr  out  C_MST_AWIDTH  address of the granted requester.
- IP2Bus_Mst_BE  out  C_MST_DWIDTH/8  byte enables of the granted requester.
- IP2Bus_MstWr_d  out  C_MST_DWIDTH  write data of the granted requester.
- IP2Bus_Mst_Lock  out  1  tied 0.
- IP2Bus_Mst_Reset  out  1  tied 0.
- Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout  in  1 each  IPIF status.
- Bus2IP_MstWr_dst_rdy_n  in  1  IPIF data ready; informational only.
- Arb_Busy  out  1  high in every state except IDLE.
- Arb_Grant  out  1  index of the current or last granted requester.

Behaviour:
- Reset (Bus2IP_Resetn=0 at clock edge):
  - State goes to IDLE.
  - IP2Bus_MstWr_Req=0, Arb_Busy=0, Arb_Grant=0.
  - All Req*_CmdAck/Cmplt/Error=0.
  - Addr/BE/data outputs = 0.
  - Reset mid-transfer aborts immediately; no completion is reported to the requester.
- States: IDLE, CMD, WAIT_CMPLT, RETRY.
- IDLE:
  - If any Req*_WrReq is high, latch the winner into the grant register, go to CMD, and set IP2Bus_MstWr_Req=1 on the same edge.
  - Latency from request to IPIF request is 1 cycle.
- CMD:
  - Addr/BE/data are combinational muxes of the granted requester's inputs, selected by the registered grant.
  - Bus2IP_Mst_CmdAck: drop IP2Bus_MstWr_Req next edge; pulse ReqG_CmdAck for 1 cycle (combinational pass-through gated by grant). Go to WAIT_CMPLT, or IDLE if Cmplt is also high that cycle.
  - Bus2IP_Mst_Rearbitrate without CmdAck: drop the request and go to RETRY.
  - Bus2IP_Mst_Cmd_Timeout: drop the request, pulse ReqG_Error and ReqG_Cmplt, go to IDLE.
- WAIT_CMPLT:
  - Bus2IP_Mst_Cmplt: pass through to ReqG_Cmplt; ReqG_Error = Bus2IP_Mst_Error that same cycle; go to IDLE.
- RETRY:
  - Count RETRY_GAP cycles with the request low, then reassert IP2Bus_MstWr_Req and return to CMD.
  - The grant is unchanged; other requesters cannot win during a retry.
- The non-granted requester never sees CmdAck/Cmplt/Error.
- Grant changes only in IDLE.
- Back-to-back: after Cmplt the state is IDLE for at least 1 cycle. A requester that drops WrReq the cycle after its CmdAck is therefore never double-granted.
- IPIF pulses arriving in IDLE are ignored.
- Addr/BE/data outputs are 0 while in IDLE.

Optional Feature:
- PLB_WR_ARB_RR_EN defined: round-robin. When both requests are high in IDLE, the requester that is not Arb_Grant wins.
- Macro undefined: fixed priority; requester 0 always wins ties.
- In both modes a single requester wins immediately.

Test Plan:
- Single request, same-cycle completion: Req0_WrReq=1, Addr=0x90000010, data=0xDEADBEEF. IPIF acks 2 cycles after IP2Bus_MstWr_Req rises, with CmdAck and Cmplt in the same cycle.
  -> IP2Bus_Mst_Addr=0x90000010 and IP2Bus_MstWr_d=0xDEADBEEF while requested; one Req0_CmdAck and one Req0_Cmplt pulse; Req1_* stay 0; Arb_Busy=0 the next cycle.
- Simultaneous requests, both held until their own CmdAck:
  - With PLB_WR_ARB_RR_EN and Arb_Grant=0 after reset: grant order 1,0,1,0 over four transfers.
  - Without the macro: requester 0 is always granted first.
- Rearbitrate with RETRY_GAP=2: assert Rearbitrate in CMD -> IP2Bus_MstWr_Req low exactly 2 cycles, then high with the same address; the other requester's WrReq is ignored meanwhile.
- Error path: Cmplt with Error=1 in WAIT_CMPLT -> Req1_Cmplt and Req1_Error pulse together for 1 cycle. Separately, Cmd_Timeout in CMD -> Error+Cmplt pulses and return to IDLE.
- Reset mid-operation: drive Bus2IP_Resetn=0 in WAIT_CMPLT -> next cycle all outputs 0 and Arb_Grant=0; a later Cmplt produces no Req*_Cmplt.

Source files
------------

// File: rtl/plb_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : plb_wr_arbiter                                                |
// | Purpose  : Shares the single PLB master IPIF write port between two      |
// |            single-beat write requesters. One requester is granted at a   |
// |            time; the grant is held until the transfer completes and the  |
// |            IPIF status pulses are routed back to the granted requester   |
// |            only. An IPIF rearbitrate is handled by dropping the request  |
// |            for RETRY_GAP cycles and reissuing it.                         |
// | Ports    : PLB_clk, Bus2IP_Resetn (sync, active low)                     |
// |            Req0_* / Req1_*   : requester side (WrReq/Addr/BE/WrData in,  |
// |                                CmdAck/Cmplt/Error out)                   |
// |            IP2Bus_*          : IPIF master command outputs               |
// |            Bus2IP_Mst_*      : IPIF master status inputs                 |
// |            Arb_Busy, Arb_Grant : arbiter status                          |
// | Options  : PLB_WR_ARB_RR_EN defined -> round-robin on ties;              |
// |            undefined -> requester 0 wins ties.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module plb_wr_arbiter #(
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32,
  parameter int RETRY_GAP    = 2
) (
  input  logic                      PLB_clk,
  input  logic                      Bus2IP_Resetn,
  input  logic                      Req0_WrReq,
  input  logic [C_MST_AWIDTH-1:0]   Req0_Addr,
  input  logic [C_MST_DWIDTH/8-1:0] Req0_BE,
  input  logic [C_MST_DWIDTH-1:0]   Req0_WrData,
  output logic                      Req0_CmdAck,
  output logic                      Req0_Cmplt,
  output logic                      Req0_Error,
  input  logic                      Req1_WrReq,
  input  logic [C_MST_AWIDTH-1:0]   Req1_Addr,
  input  logic [C_MST_DWIDTH/8-1:0] Req1_BE,
  input  logic [C_MST_DWIDTH-1:0]   Req1_WrData,
  output logic                      Req1_CmdAck,
  output logic                      Req1_Cmplt,
  output logic                      Req1_Error,
  output logic                      IP2Bus_MstWr_Req,
  output logic                      IP2Bus_MstRd_Req,
  output logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr,
  output logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE,
  output logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d,
  output logic                      IP2Bus_Mst_Lock,
  output logic                      IP2Bus_Mst_Reset,
  input  logic                      Bus2IP_Mst_CmdAck,
  input  logic                      Bus2IP_Mst_Cmplt,
  input  logic                      Bus2IP_Mst_Error,
  input  logic                      Bus2IP_Mst_Rearbitrate,
  input  logic                      Bus2IP_Mst_Cmd_Timeout,
  input  logic                      Bus2IP_MstWr_dst_rdy_n,
  output logic                      Arb_Busy,
  output logic                      Arb_Grant
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CMD        = 2'd1,
    S_WAIT_CMPLT = 2'd2,
    S_RETRY      = 2'd3
  } state_t;

  // Retry counter is loaded with GAP-1 so that exactly RETRY_GAP cycles
  // are spent in S_RETRY with the request low.
  localparam logic [3:0] c_gap_load = 4'(RETRY_GAP - 1);

  state_t     r_state, w_state_nxt;
  logic       r_grant, w_grant_nxt;
  logic       r_wr_req, w_wr_req_nxt;
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;
  logic       w_any_req;
  logic       w_win;
  logic       w_ack;
  logic       w_cmplt;
  logic       w_err;

  // Data-ready is not needed for single-beat writes.
  logic w_unused;
  assign w_unused = Bus2IP_MstWr_dst_rdy_n;

  assign w_any_req = Req0_WrReq | Req1_WrReq;

`ifdef PLB_WR_ARB_RR_EN
  // On a tie the requester that was not granted last time wins.
  assign w_win = (Req0_WrReq & Req1_WrReq) ? ~r_grant : Req1_WrReq;
`else
  // Requester 0 wins whenever it is requesting.
  assign w_win = ~Req0_WrReq;
`endif

  always_ff @(posedge PLB_clk) begin
    if (!Bus2IP_Resetn) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_wr_req  <= 1'b0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_wr_req  <= w_wr_req_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_wr_req_nxt  = r_wr_req;
    w_gap_cnt_nxt = r_gap_cnt;
    w_ack         = 1'b0;
    w_cmplt       = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt  = w_win;
          w_wr_req_nxt = 1'b1;
          w_state_nxt  = S_CMD;
        end
      end
      S_CMD: begin
        // CmdAck takes precedence over rearbitrate/timeout in the same cycle.
        if (Bus2IP_Mst_CmdAck) begin
          w_ack        = 1'b1;
          w_cmplt      = Bus2IP_Mst_Cmplt;
          w_err        = Bus2IP_Mst_Cmplt & Bus2IP_Mst_Error;
          w_wr_req_nxt = 1'b0;
          w_state_nxt  = Bus2IP_Mst_Cmplt ? S_IDLE : S_WAIT_CMPLT;
        end else if (Bus2IP_Mst_Rearbitrate) begin
          w_wr_req_nxt  = 1'b0;
          w_gap_cnt_nxt = c_gap_load;
          w_state_nxt   = S_RETRY;
        end else if (Bus2IP_Mst_Cmd_Timeout) begin
          w_wr_req_nxt = 1'b0;
          w_cmplt      = 1'b1;
          w_err        = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_WAIT_CMPLT: begin
        if (Bus2IP_Mst_Cmplt) begin
          w_cmplt     = 1'b1;
          w_err       = Bus2IP_Mst_Error;
          w_state_nxt = S_IDLE;
        end
      end
      S_RETRY: begin
        if (r_gap_cnt == 4'd0) begin
          w_wr_req_nxt = 1'b1;
          w_state_nxt  = S_CMD;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_wr_req_nxt = 1'b0;
      end
    endcase
  end

  // Status pulses go to the granted requester only.
  assign Req0_CmdAck = w_ack   & ~r_grant;
  assign Req0_Cmplt  = w_cmplt & ~r_grant;
  assign Req0_Error  = w_err   & ~r_grant;
  assign Req1_CmdAck = w_ack   &  r_grant;
  assign Req1_Cmplt  = w_cmplt &  r_grant;
  assign Req1_Error  = w_err   &  r_grant;

  // Command fields follow the registered grant and read as zero when idle.
  assign IP2Bus_Mst_Addr = (r_state == S_IDLE) ? '0 : (r_grant ? Req1_Addr   : Req0_Addr);
  assign IP2Bus_Mst_BE   = (r_state == S_IDLE) ? '0 : (r_grant ? Req1_BE     : Req0_BE);
  assign IP2Bus_MstWr_d  = (r_state == S_IDLE) ? '0 : (r_grant ? Req1_WrData : Req0_WrData);

  assign IP2Bus_MstWr_Req = r_wr_req;
  assign IP2Bus_MstRd_Req = 1'b0;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign Arb_Busy         = (r_state != S_IDLE);
  assign Arb_Grant        = r_grant;

endmodule
`default_nettype wire
